pc_run_ctrl: RTL and testbench

//  Sequencer for the program counter: owns the PC register and decides when it

---
 rtl/pc_run_ctrl.sv | 117 +++++++++++
 tb/tb_pc_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_run_ctrl.sv
// rtl/pc_run_ctrl.sv - PC sequencer: free-run/step/load control and LED byte display
// Optional breakpoint-to-HALT support is enabled by defining BREAKPOINT_EN.
module pc_run_ctrl #(
  parameter int              PC_W     = 32,
  parameter int              DIV_W    = 24,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Step,
  input  logic             Load,
  input  logic [PC_W-1:0]  LoadAddr,
  input  logic [DIV_W-1:0] Div,
  input  logic             BpEn,
  input  logic [PC_W-1:0]  BpAddr,
  input  logic [1:0]       SW,
  output logic [PC_W-1:0]  PC,
  output logic             PcTick,
  output logic [1:0]       State,
  output logic             Halted,
  output logic [7:0]       LED
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic             step_s1, step_s2, step_s2_d;
  logic             step_evt;
  logic [DIV_W-1:0] presc, presc_nxt, div_eff;
  logic             advance;
  logic             bp_hit;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_shift;

  assign div_eff  = (Div == '0) ? DIV_W'(1) : Div;
  assign pc_inc   = PC + PC_W'(PC_STEP);
  assign step_evt = step_s2 & ~step_s2_d;
  assign pc_shift = PC >> {SW, 3'b000};
  assign State    = state;

`ifdef BREAKPOINT_EN
  assign bp_hit = BpEn && (pc_inc == BpAddr);
  assign Halted = (state == HALT);
`else
  logic unused_bp;
  assign unused_bp = ^{BpEn, BpAddr};
  assign bp_hit    = 1'b0;
  assign Halted    = 1'b0;
`endif

  // Prescaler only counts while running; any other path leaves it at zero.
  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (Run)           state_nxt = RUN;
        else if (step_evt) state_nxt = STEP;
      end
      RUN: begin
        if (!Run) begin
          state_nxt = IDLE;
        end else if (presc >= div_eff - DIV_W'(1)) begin
          advance = 1'b1;
          if (bp_hit) state_nxt = HALT;
        end else begin
          presc_nxt = presc + DIV_W'(1);
        end
      end
      STEP: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      HALT: begin
        if (!Run) state_nxt = IDLE;
      end
    endcase
    // Load pre-empts any advance and freezes the state, except STEP which must still retire.
    if (Load) begin
      advance   = 1'b0;
      presc_nxt = '0;
      state_nxt = (state == STEP) ? IDLE : state;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      presc     <= '0;
      PC        <= RESET_PC;
      PcTick    <= 1'b0;
      LED       <= 8'h00;
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_s2_d <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      PcTick    <= advance;
      LED       <= pc_shift[7:0];
      step_s1   <= Step;
      step_s2   <= step_s1;
      step_s2_d <= step_s2;
      if (Load)         PC <= LoadAddr;
      else if (advance) PC <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_run_ctrl.sv
// tb/tb_pc_run_ctrl.sv - self-checking bench for pc_run_ctrl (directed, table and random vs model)
module tb_pc_run_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Run, Step, Load, BpEn;
  logic [31:0] LoadAddr, BpAddr;
  logic [23:0] Div;
  logic [1:0]  SW;
  logic [31:0] PC;
  logic        PcTick, Halted;
  logic [1:0]  State;
  logic [7:0]  LED;

  pc_run_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Step(Step), .Load(Load), .LoadAddr(LoadAddr),
    .Div(Div), .BpEn(BpEn), .BpAddr(BpAddr), .SW(SW), .PC(PC), .PcTick(PcTick),
    .State(State), .Halted(Halted), .LED(LED)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sw;
    logic [7:0] led;
  } led_vec_t;
  led_vec_t led_tab[4];

  // Reference model: mode 0 idle, 1 run, 2 step, 3 halt
  logic [31:0] m_pc;
  int          m_mode, m_cnt;
  logic        m_tick;
  logic [7:0]  m_led;
  logic        hist[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task model_edge();
    int   d, nmode, ncnt;
    logic adv, evt;
    logic [31:0] sh;
    if (Rst) begin
      m_pc = 32'h0; m_mode = 0; m_cnt = 0; m_tick = 1'b0; m_led = 8'h00;
      hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
      return;
    end
    // Step event: button seen high two samples ago but not three samples ago
    evt   = hist[1] && !hist[2];
    d     = (Div == 0) ? 1 : int'(Div);
    adv   = 1'b0;
    nmode = m_mode;
    ncnt  = 0;
    case (m_mode)
      0: if (Run) nmode = 1; else if (evt) nmode = 2;
      1: if (!Run) nmode = 0; else if (m_cnt + 1 >= d) adv = 1'b1; else ncnt = m_cnt + 1;
      2: begin adv = 1'b1; nmode = 0; end
      default: if (!Run) nmode = 0;
    endcase
`ifdef BREAKPOINT_EN
    if (adv && m_mode == 1 && BpEn && (m_pc + 32'd4) == BpAddr) nmode = 3;
`endif
    sh    = m_pc >> (8 * SW);
    m_led = sh[7:0];
    if (Load) begin
      adv   = 1'b0;
      ncnt  = 0;
      nmode = (m_mode == 2) ? 0 : m_mode;
      m_pc  = LoadAddr;
    end else if (adv) begin
      m_pc = m_pc + 32'd4;
    end
    m_tick  = adv;
    m_mode  = nmode;
    m_cnt   = ncnt;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = Step;
  endtask

  initial begin
    int          ticks;
    int          mask;
    logic [7:0]  prev;
    logic        seen;

    led_tab[0] = '{2'b01, 8'h56};
    led_tab[1] = '{2'b10, 8'h34};
    led_tab[2] = '{2'b11, 8'h12};
    led_tab[3] = '{2'b00, 8'h78};

    Rst = 1'b1; Run = 1'b0; Step = 1'b0; Load = 1'b0; LoadAddr = '0;
    Div = 24'd1; BpEn = 1'b0; BpAddr = '0; SW = 2'b00;
    cyc(2);
    Rst = 1'b0;
    chk("rst_pc", PC, 32'h0);
    chk("rst_state", 32'(State), 32'h0);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_tick", 32'(PcTick), 32'h0);
    chk("rst_halted", 32'(Halted), 32'h0);

    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (PcTick) ticks++;
    end
    chk("idle_ticks", ticks, 0);
    chk("idle_pc", PC, 32'h0);
    chk("idle_state", 32'(State), 32'h0);

    // Step button: STEP entered at edge 3, PC advances at edge 4
    Step = 1'b1;
    cyc(3);
    chk("step_state_e3", 32'(State), 32'h2);
    chk("step_pc_e3", PC, 32'h0);
    cyc(1);
    chk("step_pc_e4", PC, 32'h4);
    chk("step_tick_e4", 32'(PcTick), 32'h1);
    chk("step_state_e4", 32'(State), 32'h0);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (PcTick) ticks++;
    end
    chk("step_held_ticks", ticks, 0);
    chk("step_held_pc", PC, 32'h4);
    Step = 1'b0;
    cyc(3);

    // Free run with Div=3 for 10 clocks from PC=0
    Load = 1'b1; LoadAddr = 32'h0;
    cyc(1);
    Load = 1'b0;
    chk("load0_pc", PC, 32'h0);
    Div = 24'd3; Run = 1'b1;
    mask = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (PcTick) mask |= (1 << i);
    end
    chk("run_div3_ticks", mask, 32'h248);
    chk("run_div3_pc", PC, 32'h0C);

    Div = 24'd0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (PcTick) ticks++;
    end
    chk("run_div0_ticks", ticks, 5);
    chk("run_div0_pc", PC, 32'h20);

    // Load on a terminal-count edge wins over the advance
    Div = 24'd3;
    cyc(2);
    chk("pre_load_pc", PC, 32'h20);
    Load = 1'b1; LoadAddr = 32'hFFFF_FFFC;
    cyc(1);
    Load = 1'b0;
    chk("load_term_pc", PC, 32'hFFFF_FFFC);
    chk("load_term_tick", 32'(PcTick), 32'h0);
    chk("load_term_state", 32'(State), 32'h1);
    cyc(2);
    chk("wrap_pre_pc", PC, 32'hFFFF_FFFC);
    cyc(1);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_tick", 32'(PcTick), 32'h1);
    Run = 1'b0;
    cyc(1);
    chk("stop_state", 32'(State), 32'h0);

    // LED byte select, table driven
    SW = 2'b00;
    Load = 1'b1; LoadAddr = 32'h1234_5678;
    cyc(1);
    Load = 1'b0;
    cyc(1);
    chk("led_sw00", 32'(LED), 32'h78);
    prev = 8'h78;
    for (int i = 0; i < 4; i++) begin
      SW = led_tab[i].sw;
      #1;
      chk("led_latency", 32'(LED), 32'(prev));
      cyc(1);
      chk("led_sel", 32'(LED), 32'(led_tab[i].led));
      prev = led_tab[i].led;
    end

`ifdef BREAKPOINT_EN
    Load = 1'b1; LoadAddr = 32'h0;
    cyc(1);
    Load = 1'b0;
    BpEn = 1'b1; BpAddr = 32'h10; Div = 24'd1; Run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(1);
      if (Halted) seen = 1'b1;
    end
    chk("bp_reached", 32'(seen), 32'h1);
    chk("bp_state", 32'(State), 32'h3);
    chk("bp_pc", PC, 32'h10);
    cyc(3);
    chk("bp_hold_pc", PC, 32'h10);
    Run = 1'b0;
    cyc(1);
    chk("bp_release", 32'(State), 32'h0);
    chk("bp_release_halted", 32'(Halted), 32'h0);
    BpEn = 1'b0;
`else
    seen = 1'b0;
`endif

    // Reset while running
    Div = 24'd1; Run = 1'b1;
    cyc(3);
    Rst = 1'b1;
    cyc(1);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_state", 32'(State), 32'h0);
    chk("midrst_led", 32'(LED), 32'h0);
    chk("midrst_tick", 32'(PcTick), 32'h0);
    Rst = 1'b0; Run = 1'b0;

    // Randomized run against the reference model
    m_pc = '0; m_mode = 0; m_cnt = 0; m_tick = 1'b0; m_led = '0;
    hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      Rst = (i < 2) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 11) == 0) Run = ~Run;
      if ($urandom_range(0, 5) == 0) Step = ~Step;
      Load     = ($urandom_range(0, 19) == 0);
      LoadAddr = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(0, 15) == 0) Div = 24'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) SW = 2'($urandom_range(0, 3));
      BpEn   = ($urandom_range(0, 1) == 1);
      BpAddr = 32'($urandom_range(0, 15)) << 2;
      @(posedge Clk);
      model_edge();
      #1;
      chk("rnd_pc", PC, m_pc);
      chk("rnd_state", 32'(State), 32'(m_mode));
      chk("rnd_tick", 32'(PcTick), 32'(m_tick));
      chk("rnd_led", 32'(LED), 32'(m_led));
      chk("rnd_halted", 32'(Halted), (m_mode == 3) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
